// File: rtl/hex_led_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hex_led_arbiter
//  Description : Two-requester arbiter for six 7-segment displays and a
//                10-bit LED bar. Requester 0 is the CPU PIO path and
//                requester 1 is the hardware status path. Ties are resolved
//                round-robin. A contested owner is preempted after MAX_HOLD
//                cycles of tenure. Every handover passes through a one-cycle
//                blank GAP state.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_led_arbiter #(
    parameter int MAX_HOLD = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  req,
    input  logic [23:0] digits0,
    input  logic [23:0] digits1,
    input  logic [9:0]  leds0,
    input  logic [9:0]  leds1,
    output logic [1:0]  gnt,
    output logic [6:0]  hex0_export,
    output logic [6:0]  hex1_export,
    output logic [6:0]  hex2_export,
    output logic [6:0]  hex3_export,
    output logic [6:0]  hex4_export,
    output logic [6:0]  hex5_export,
    output logic [9:0]  led_export
);

    // ------------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_OWN0 = 2'd1;
    localparam logic [1:0] c_OWN1 = 2'd2;
    localparam logic [1:0] c_GAP  = 2'd3;

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [6:0]       c_BLANK     = 7'h7F;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       w_arb_state;
    logic             r_last_owner;
    logic [CNT_W-1:0] r_cnt;
    logic             w_hold_done;
    logic             w_owning;
    logic [23:0]      w_sel_digits;
    logic [9:0]       w_sel_leds;
    logic [6:0]       r_hex [6];
    logic [9:0]       r_led;

    // ------------------------------------------------------------------------
    // Active-low 7-segment decode, bit 6 = g .. bit 0 = a
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Tenure has run its full length; only matters when the other side asks.
    assign w_hold_done = (r_cnt == c_HOLD_LAST);
    assign w_owning    = (r_state == c_OWN0) || (r_state == c_OWN1);

    // Idle/gap arbitration: single requester wins outright, a tie goes to
    // whichever requester did not own the display last.
    always_comb begin
        w_arb_state = c_IDLE;
        case (req)
            2'b01:   w_arb_state = c_OWN0;
            2'b10:   w_arb_state = c_OWN1;
            2'b11:   w_arb_state = r_last_owner ? c_OWN0 : c_OWN1;
            default: w_arb_state = c_IDLE;
        endcase
    end

    // Next-state logic: release and preemption collapse into one GAP step.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE, c_GAP: w_state_nxt = w_arb_state;
            c_OWN0: begin
                if (!req[0] || (w_hold_done && req[1])) begin
                    w_state_nxt = c_GAP;
                end
            end
            c_OWN1: begin
                if (!req[1] || (w_hold_done && req[0])) begin
                    w_state_nxt = c_GAP;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Remember who gave up the display so the next tie favours the other.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_last_owner <= 1'b1;
        end else if (w_state_nxt == c_GAP) begin
            if (r_state == c_OWN0) begin
                r_last_owner <= 1'b0;
            end else if (r_state == c_OWN1) begin
                r_last_owner <= 1'b1;
            end
        end
    end

    // Hold counter: zero outside tenure so each OWN entry starts at 0,
    // counts up while owning and sticks at the last hold value.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cnt <= '0;
        end else if (w_owning) begin
            if (!w_hold_done) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Moore grant decode straight from the state register.
    assign gnt = {(r_state == c_OWN1), (r_state == c_OWN0)};

    // Source data follows the current owner; sampled live every cycle.
    assign w_sel_digits = (r_state == c_OWN1) ? digits1 : digits0;
    assign w_sel_leds   = (r_state == c_OWN1) ? leds1   : leds0;

    // Registered display drive, one per digit; blank when nobody owns it.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_hex
            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    r_hex[gi] <= c_BLANK;
                end else if (w_owning) begin
                    r_hex[gi] <= seg_decode(w_sel_digits[4*gi +: 4]);
                end else begin
                    r_hex[gi] <= c_BLANK;
                end
            end
        end
    endgenerate

    // Registered LED drive; dark when nobody owns it.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_led <= '0;
        end else if (w_owning) begin
            r_led <= w_sel_leds;
        end else begin
            r_led <= '0;
        end
    end

    assign hex0_export = r_hex[0];
    assign hex1_export = r_hex[1];
    assign hex2_export = r_hex[2];
    assign hex3_export = r_hex[3];
    assign hex4_export = r_hex[4];
    assign hex5_export = r_hex[5];
    assign led_export  = r_led;

endmodule
`default_nettype wire

// File: tb/tb_hex_led_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hex_led_arbiter
//  Description : Directed self-checking bench for hex_led_arbiter with
//                MAX_HOLD = 4. Inputs change and outputs are sampled on the
//                falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_led_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [23:0] digits0;
    logic [23:0] digits1;
    logic [9:0]  leds0;
    logic [9:0]  leds1;
    logic [1:0]  gnt;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    logic [9:0]  led;

    logic [6:0]  w_hex [6];
    logic [6:0]  c_seg [16];
    int          n_assert;
    int          n_fail;

    hex_led_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (26)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .req           (req),
        .digits0       (digits0),
        .digits1       (digits1),
        .leds0         (leds0),
        .leds1         (leds1),
        .gnt           (gnt),
        .hex0_export   (hex0),
        .hex1_export   (hex1),
        .hex2_export   (hex2),
        .hex3_export   (hex3),
        .hex4_export   (hex4),
        .hex5_export   (hex5),
        .led_export    (led)
    );

    assign w_hex[0] = hex0;
    assign w_hex[1] = hex1;
    assign w_hex[2] = hex2;
    assign w_hex[3] = hex3;
    assign w_hex[4] = hex4;
    assign w_hex[5] = hex5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset held, then released with no requests: everything blank.
    task automatic test_reset();
        rst_n = 1'b0;
        req = 2'b00;
        repeat (3) @(negedge clk);
        n_assert++;
        if (gnt !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt got %b expected 00", gnt);
        end
        for (int k = 0; k < 6; k++) begin
            n_assert++;
            if (w_hex[k] !== 7'h7F) begin
                n_fail++; $display("FAIL reset_hex%0d got %h expected 7f", k, w_hex[k]);
            end
        end
        n_assert++;
        if (led !== 10'h000) begin
            n_fail++; $display("FAIL reset_led got %h expected 000", led);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_assert++;
            if (gnt !== 2'b00 || hex0 !== 7'h7F || hex5 !== 7'h7F || led !== 10'h000) begin
                n_fail++;
                $display("FAIL idle_c%0d gnt %b hex0 %h hex5 %h led %h expected 00 7f 7f 000",
                         c, gnt, hex0, hex5, led);
            end
        end
    endtask

    // Single requester: one-cycle grant latency then one-cycle data latency.
    task automatic test_single_grant();
        logic [6:0] exp [6];
        digits0 = 24'h012345;
        leds0 = 10'h3FF;
        req = 2'b01;
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b01) begin
            n_fail++; $display("FAIL grant0_latency got %b expected 01", gnt);
        end
        n_assert++;
        if (hex0 !== 7'h7F || led !== 10'h000) begin
            n_fail++; $display("FAIL grant0_first_blank hex0 %h led %h expected 7f 000", hex0, led);
        end
        @(negedge clk);
        exp = '{7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
        for (int k = 0; k < 6; k++) begin
            n_assert++;
            if (w_hex[k] !== exp[k]) begin
                n_fail++; $display("FAIL data0_hex%0d got %h expected %h", k, w_hex[k], exp[k]);
            end
        end
        n_assert++;
        if (led !== 10'h3FF) begin
            n_fail++; $display("FAIL data0_led got %h expected 3ff", led);
        end
        // Live source change during tenure shows one cycle later.
        digits0 = 24'hFEDCBA;
        leds0 = 10'h155;
        @(negedge clk);
        exp = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        for (int k = 0; k < 6; k++) begin
            n_assert++;
            if (w_hex[k] !== exp[k]) begin
                n_fail++; $display("FAIL live_hex%0d got %h expected %h", k, w_hex[k], exp[k]);
            end
        end
        n_assert++;
        if (led !== 10'h155) begin
            n_fail++; $display("FAIL live_led got %h expected 155", led);
        end
    endtask

    // Full decoder table sweep while requester 0 keeps the display.
    task automatic test_decode();
        logic [23:0] words [3];
        logic [23:0] w;
        logic [3:0]  nib;
        words = '{24'h543210, 24'hBA9876, 24'hFEDCBA};
        for (int i = 0; i < 3; i++) begin
            digits0 = words[i];
            w = words[i];
            @(negedge clk);
            for (int k = 0; k < 6; k++) begin
                nib = w[4*k +: 4];
                n_assert++;
                if (w_hex[k] !== c_seg[nib]) begin
                    n_fail++;
                    $display("FAIL decode_%h_hex%0d got %h expected %h", nib, k, w_hex[k], c_seg[nib]);
                end
            end
        end
    endtask

    // Release to idle: grant drops next cycle, outputs blank a cycle later.
    task automatic test_release_idle();
        req = 2'b00;
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b00 || hex0 !== 7'h08) begin
            n_fail++; $display("FAIL rel0_gap gnt %b hex0 %h expected 00 08", gnt, hex0);
        end
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b00 || hex0 !== 7'h7F || led !== 10'h000) begin
            n_fail++; $display("FAIL rel0_blank gnt %b hex0 %h led %h expected 00 7f 000", gnt, hex0, led);
        end
    endtask

    // Tie after reset: requester 0 first, preempted after 4 cycles, then 1.
    task automatic test_round_robin();
        logic [1:0] exp [11];
        exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        digits1 = 24'h888888;
        leds1 = 10'h2AA;
        req = 2'b11;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            n_assert++;
            if (gnt !== exp[c]) begin
                n_fail++; $display("FAIL rr_c%0d got %b expected %b", c, gnt, exp[c]);
            end
        end
    endtask

    // Handover 0 -> 1, then owner 1 releases with nobody waiting, then returns.
    task automatic test_release_own1();
        req = 2'b10;
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b00) begin
            n_fail++; $display("FAIL hand_gap got %b expected 00", gnt);
        end
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b10 || hex0 !== 7'h7F) begin
            n_fail++; $display("FAIL hand_own1 gnt %b hex0 %h expected 10 7f", gnt, hex0);
        end
        @(negedge clk);
        n_assert++;
        if (hex0 !== 7'h00 || hex5 !== 7'h00 || led !== 10'h2AA) begin
            n_fail++; $display("FAIL own1_data hex0 %h hex5 %h led %h expected 00 00 2aa", hex0, hex5, led);
        end
        req = 2'b00;
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b00 || hex0 !== 7'h00) begin
            n_fail++; $display("FAIL rel1_gap gnt %b hex0 %h expected 00 00", gnt, hex0);
        end
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b00 || hex0 !== 7'h7F || led !== 10'h000) begin
            n_fail++; $display("FAIL rel1_blank gnt %b hex0 %h led %h expected 00 7f 000", gnt, hex0, led);
        end
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b00) begin
            n_fail++; $display("FAIL rel1_idle got %b expected 00", gnt);
        end
        req = 2'b10;
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b10) begin
            n_fail++; $display("FAIL regrant1 got %b expected 10", gnt);
        end
    endtask

    // Uncontested owner keeps the grant past saturation; contention then
    // preempts immediately.
    task automatic test_hold();
        req = 2'b01;
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b00) begin
            n_fail++; $display("FAIL hold_gap got %b expected 00", gnt);
        end
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b01) begin
            n_fail++; $display("FAIL hold_grant got %b expected 01", gnt);
        end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            n_assert++;
            if (gnt !== 2'b01) begin
                n_fail++; $display("FAIL hold_c%0d got %b expected 01", c, gnt);
            end
        end
        n_assert++;
        if (dut.r_cnt !== 26'd3) begin
            n_fail++; $display("FAIL hold_cnt got %0d expected 3", dut.r_cnt);
        end
        req = 2'b11;
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b00) begin
            n_fail++; $display("FAIL sat_preempt got %b expected 00", gnt);
        end
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b10) begin
            n_fail++; $display("FAIL sat_next_owner got %b expected 10", gnt);
        end
    endtask

    // Asynchronous reset in OWN1 clears outputs without a clock edge.
    task automatic test_reset_mid();
        req = 2'b10;
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b10 || hex0 !== 7'h00) begin
            n_fail++; $display("FAIL pre_reset gnt %b hex0 %h expected 10 00", gnt, hex0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_assert++;
        if (gnt !== 2'b00) begin
            n_fail++; $display("FAIL async_gnt got %b expected 00", gnt);
        end
        for (int k = 0; k < 6; k++) begin
            n_assert++;
            if (w_hex[k] !== 7'h7F) begin
                n_fail++; $display("FAIL async_hex%0d got %h expected 7f", k, w_hex[k]);
            end
        end
        n_assert++;
        if (led !== 10'h000) begin
            n_fail++; $display("FAIL async_led got %h expected 000", led);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_assert++;
        if (gnt !== 2'b10) begin
            n_fail++; $display("FAIL resume_gnt got %b expected 10", gnt);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        c_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst_n = 1'b0;
        req = 2'b00;
        digits0 = '0;
        digits1 = '0;
        leds0 = '0;
        leds1 = '0;
        test_reset();
        test_single_grant();
        test_decode();
        test_release_idle();
        test_round_robin();
        test_release_own1();
        test_hold();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
